// File: rtl/mem_code_loader_if.sv
// Purpose: stream-in and line-write request signals of the boot code loader.
// Latency: none, wires only.
// Backpressure: in_ready stalls the word stream; mem_req_ready stalls line writes.
// Ports: in_valid/in_ready/in_data/in_last      - 32-bit image word stream
//        mem_req_valid/ready/line/data/mask     - masked 128-bit line write
// Modports: master = the loader, slave = the stream source plus memory core.
interface mem_code_loader_if #(
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                             in_valid;
  logic                             in_ready;
  logic [WORD_WIDTH-1:0]            in_data;
  logic                             in_last;
  logic                             mem_req_valid;
  logic                             mem_req_ready;
  logic [ADDR_WIDTH-5:0]            mem_req_line;
  logic [WORD_WIDTH*LINE_WORDS-1:0] mem_req_data;
  logic [LINE_WORDS-1:0]            mem_req_mask;

  modport master (
    input  in_valid, in_data, in_last, mem_req_ready,
    output in_ready, mem_req_valid, mem_req_line, mem_req_data, mem_req_mask
  );

  modport slave (
    output in_valid, in_data, in_last, mem_req_ready,
    input  in_ready, mem_req_valid, mem_req_line, mem_req_data, mem_req_mask
  );
endinterface

// File: rtl/mem_code_loader.sv
// Purpose: packs a boot image word stream into masked line writes and holds the CPU in reset meanwhile.
// Latency: last word accepted at N -> mem_req_valid at N+1 -> cpu_hold low at N+2 when ready.
// Backpressure: in_ready low while a line write is pending; mem_req_* frozen until mem_req_ready.
// Ports: clock, reset (async active-low), start/base_addr (load kick-off),
//        bus (mem_code_loader_if.master: word stream in, line writes out),
//        cpu_hold, done, word_count (words accepted since last start).
module mem_code_loader #(
  parameter int WORD_WIDTH  = 32,
  parameter int LINE_WORDS  = 4,
  parameter int LINE_WIDTH  = WORD_WIDTH * LINE_WORDS,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  mem_code_loader_if.master      bus,
  output logic                   cpu_hold,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] word_count
);
  localparam int SLOT_W     = $clog2(LINE_WORDS);
  localparam int LINE_SHIFT = SLOT_W + 2;
  localparam int LINE_AW    = ADDR_WIDTH - LINE_SHIFT;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [LINE_AW-1:0]     line_q, line_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [LINE_WIDTH-1:0]  buf_q, buf_d;
  logic [LINE_WORDS-1:0]  mask_q, mask_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   last_q, last_d;
  logic                   in_ready_q, in_ready_d;
  logic                   req_valid_q, req_valid_d;
  logic                   cpu_hold_q, cpu_hold_d;
  logic                   done_q, done_d;

  // Base address is word aligned; the byte offset bits carry no information.
  logic unused_base_lsb;
  assign unused_base_lsb = ^base_addr[1:0];

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    slot_d      = slot_q;
    buf_d       = buf_q;
    mask_d      = mask_q;
    count_d     = count_q;
    last_d      = last_q;
    in_ready_d  = in_ready_q;
    req_valid_d = req_valid_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = FILL;
          line_d     = base_addr[ADDR_WIDTH-1:LINE_SHIFT];
          slot_d     = base_addr[LINE_SHIFT-1:2];
          buf_d      = '0;
          mask_d     = '0;
          count_d    = '0;
          last_d     = 1'b0;
          in_ready_d = 1'b1;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
        end
      end
      FILL: begin
        if (bus.in_valid && in_ready_q) begin
          for (int k = 0; k < LINE_WORDS; k++) begin
            if (slot_q == SLOT_W'(k)) begin
              buf_d[k*WORD_WIDTH +: WORD_WIDTH] = bus.in_data;
              mask_d[k]                         = 1'b1;
            end
          end
          count_d = count_q + COUNT_WIDTH'(1);
          // A line goes out when full or when the image ends; since we only
          // get here after accepting a word, an all-zero mask is impossible.
          if (slot_q == SLOT_W'(LINE_WORDS - 1) || bus.in_last) begin
            state_d     = WRITE;
            in_ready_d  = 1'b0;
            req_valid_d = 1'b1;
            last_d      = bus.in_last;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      WRITE: begin
        if (bus.mem_req_ready) begin
          line_d      = line_q + LINE_AW'(1);
          slot_d      = '0;
          mask_d      = '0;
          buf_d       = '0;  // unused slots of the next line must read as 0
          req_valid_d = 1'b0;
          if (last_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = FILL;
            in_ready_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      line_q      <= '0;
      slot_q      <= '0;
      buf_q       <= '0;
      mask_q      <= '0;
      count_q     <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      req_valid_q <= 1'b0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      slot_q      <= slot_d;
      buf_q       <= buf_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      req_valid_q <= req_valid_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_line  = line_q;
  assign bus.mem_req_data  = buf_q;
  assign bus.mem_req_mask  = mask_q;
  assign cpu_hold          = cpu_hold_q;
  assign done              = done_q;
  assign word_count        = count_q;
endmodule

// File: doc/mem_code_loader.md
Name: mem_code_loader

Overview:
- Boot-time program loader that sits upstream of the memory core.
- Accepts a stream of 32-bit instruction/data words and packs them into 128-bit memory lines (4 words per line).
- Issues masked line writes on a valid/ready request port toward the memory core.
- Holds the CPU core in reset until the last line write is accepted, so images are loaded in hardware instead of by a bench backdoor.

Parameters:
- WORD_WIDTH, 32, width of one stream word.
- LINE_WORDS, 4, words per memory line; fixed power of two.
- LINE_WIDTH, 128, WORD_WIDTH*LINE_WORDS.
- ADDR_WIDTH, 32, byte-address width.
- COUNT_WIDTH, 16, width of the accepted-word counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load at base_addr.
- base_addr  in  ADDR_WIDTH  byte address of the first word; must be word aligned (bits [1:0] ignored).
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader can accept a stream word.
- in_data  in  WORD_WIDTH  stream word.
- in_last  in  1  marks the final word of the image.
- mem_req_valid  out  1  line write request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_line  out  ADDR_WIDTH-4  line address (byte address >> 4).
- mem_req_data  out  LINE_WIDTH  line data; word k occupies bits [32k +: 32].
- mem_req_mask  out  LINE_WORDS  per-word write enable.
- cpu_hold  out  1  high keeps the CPU core in reset.
- done  out  1  image fully written.
- word_count  out  COUNT_WIDTH  words accepted since the last start.

Behaviour:
- Reset values (async, while reset=0):
  - state=IDLE; cpu_hold=1; done=0; in_ready=0; mem_req_valid=0.
  - mem_req_line=0; mem_req_data=0; mem_req_mask=0; word_count=0.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start: latch line pointer = base_addr>>4, slot = base_addr[3:2], clear buffer/mask/word_count -> FILL.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready: write in_data into buffer slot, set mask bit, word_count+1 (wraps modulo 2^COUNT_WIDTH).
  - If slot==3 or in_last: -> WRITE next cycle; in_last is latched as last_flag.
  - Otherwise slot+1.
- WRITE:
  - in_ready=0; mem_req_valid=1; outputs stable until accepted.
  - Unused slots carry 0 data with mask bit 0.
  - On mem_req_ready: line pointer+1, slot=0, mask cleared.
  - Next state: DONE if last_flag, else FILL.
  - Minimum 1 cycle per line write; backpressure holds all mem_req_* unchanged.
- DONE:
  - done=1; cpu_hold drops to 0 on the cycle after the final handshake (registered) and stays 0.
  - start: re-enter FILL as from IDLE, cpu_hold=1 and done=0 on the next cycle.
- start while in FILL or WRITE is ignored.
- in_valid in IDLE/DONE/WRITE is not accepted (in_ready=0).
- Unaligned base: the first line is partial (mask low bits 0).
- Line pointer wraps modulo 2^(ADDR_WIDTH-4).
- in_last on a word in slot 3: exactly one write, no extra empty line.
- An empty line (mask=0) is never issued.
- Reset mid-load: abort immediately.
  - The in-flight request is dropped with no handshake.
  - cpu_hold=1 and done=0 until a new start completes.
- Latency: last stream word accepted at cycle N -> mem_req_valid at N+1 -> if ready, cpu_hold=0 at N+2.

Test Plan:
- Aligned load: start base 0x1000, 16 words 0..15 (in_last on 15), ready=1 -> 4 writes to lines 0x100..0x103, each mask 4'hF, line 0x101 data {7,6,5,4}; word_count=16; cpu_hold falls 2 cycles after word 15.
- Unaligned load: base 0x1808, words 0xA,0xB,0xC (last on 0xC) -> line 0x180 mask 4'b1100, data slots 2,3 = 0xA,0xB; line 0x181 mask 4'b0001, slot0 = 0xC; done=1.
- Backpressure: mem_req_ready low 5 cycles during the first write -> mem_req_* stable, in_ready=0 throughout, no word lost; final lines identical to the aligned case.
- Single word: base 0x1004, one word 0xDEADBEEF with last -> one write, line 0x100, mask 4'b0010; word_count=1.
- Start ignored while busy: pulse start base 0x2000 mid-FILL -> line addresses continue from the original base, no restart.
- Reset mid-load: assert reset during WRITE after 6 words -> mem_req_valid=0 and cpu_hold=1 immediately; a fresh 4-word load at 0x1000 then completes with one write, mask 4'hF.
